// File: rtl/fetch_prefetch_queue_if.sv
// Signal bundle tying the prefetch queue to the instruction memory, the execute redirect path and decode.
// The master modport is the prefetch queue's view; the slave modport is the surrounding pipeline's view.
interface fetch_prefetch_queue_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic                   busy;

    modport master (
        input  redirect_valid, redirect_target, imem_req_ready,
               imem_resp_valid, imem_resp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, busy
    );

    modport slave (
        output redirect_valid, redirect_target, imem_req_ready,
               imem_resp_valid, imem_resp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, busy
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: owns the PC, keeps up to MAX_OUTSTANDING requests in flight to instruction
// memory and buffers in-order {pc, instr} results in a DEPTH-entry FIFO for decode.
module fetch_prefetch_queue_chk #(
    parameter int OUT_W = 2
) (
    input logic             clk,
    input logic             reset,
    input logic             imem_resp_valid,
    input logic [OUT_W-1:0] outstanding
);
    // A response with nothing outstanding means memory and fetch disagree about request history.
    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && (outstanding == '0)));
endmodule

module fetch_prefetch_queue #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INSTR_WIDTH     = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = {ADDR_WIDTH{1'b0}}
) (
    input logic                    clk,
    input logic                    reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(32'd4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1'b1);

    logic [ADDR_WIDTH-1:0]  fetch_pc_r, fetch_pc_nx_s;
    logic [ADDR_WIDTH-1:0]  resp_pc_r, resp_pc_nx_s;
    logic [CNT_W-1:0]       q_count_r, q_count_nx_s;
    logic [OUT_W-1:0]       outstanding_r, outstanding_nx_s;
    logic [OUT_W-1:0]       drop_cnt_r, drop_cnt_nx_s;
    logic [PTR_W-1:0]       head_r, head_nx_s;
    logic [PTR_W-1:0]       tail_r, tail_nx_s;
    logic                   started_r;
    logic [ADDR_WIDTH-1:0]  pc_mem_r    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_r [DEPTH];

    logic                  credit_s;
    logic                  req_valid_s;
    logic                  issue_s;
    logic                  resp_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  out_valid_s;
    logic [ADDR_WIDTH-1:0] target_s;

    // Requests still in flight reserve FIFO space, stale ones included, so a response always has a slot.
    assign credit_s    = (SUM_W'(q_count_r) + SUM_W'(outstanding_r)) < SUM_W'(DEPTH);
    assign req_valid_s = !reset && started_r && !bus.redirect_valid
                         && (outstanding_r < OUT_W'(MAX_OUTSTANDING)) && credit_s;
    assign issue_s     = req_valid_s && bus.imem_req_ready;
    assign resp_s      = bus.imem_resp_valid && (outstanding_r != '0);
    assign push_s      = resp_s && (drop_cnt_r == '0) && !bus.redirect_valid;
    assign out_valid_s = !reset && (q_count_r != '0);
    assign pop_s       = out_valid_s && bus.out_ready && !bus.redirect_valid;
    assign target_s    = bus.redirect_target & ALIGN_MASK;

    // Next-state for PCs, pointers and counters; a redirect flushes and turns in-flight work into drops.
    always_comb begin
        fetch_pc_nx_s    = fetch_pc_r;
        resp_pc_nx_s     = resp_pc_r;
        q_count_nx_s     = q_count_r;
        outstanding_nx_s = outstanding_r;
        drop_cnt_nx_s    = drop_cnt_r;
        head_nx_s        = head_r;
        tail_nx_s        = tail_r;
        if (bus.redirect_valid) begin
            fetch_pc_nx_s    = target_s;
            resp_pc_nx_s     = target_s;
            q_count_nx_s     = '0;
            head_nx_s        = '0;
            tail_nx_s        = '0;
            outstanding_nx_s = outstanding_r - OUT_W'(resp_s);
            drop_cnt_nx_s    = outstanding_r - OUT_W'(resp_s);
        end else begin
            if (issue_s) begin
                fetch_pc_nx_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nx_s = fetch_pc_r;
            end
            // Kept responses are sequential from the last redirect, so their PC is just a running count.
            if (push_s) begin
                resp_pc_nx_s = resp_pc_r + PC_STEP;
                tail_nx_s    = tail_r + PTR_ONE;
            end else begin
                resp_pc_nx_s = resp_pc_r;
                tail_nx_s    = tail_r;
            end
            if (pop_s) begin
                head_nx_s = head_r + PTR_ONE;
            end else begin
                head_nx_s = head_r;
            end
            if (resp_s && (drop_cnt_r != '0)) begin
                drop_cnt_nx_s = drop_cnt_r - OUT_W'(1'b1);
            end else begin
                drop_cnt_nx_s = drop_cnt_r;
            end
            q_count_nx_s     = q_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            outstanding_nx_s = outstanding_r + OUT_W'(issue_s) - OUT_W'(resp_s);
        end
    end

    // Control state register; started_r holds issue off for one cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            q_count_r     <= '0;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
            head_r        <= '0;
            tail_r        <= '0;
            started_r     <= 1'b0;
        end else begin
            fetch_pc_r    <= fetch_pc_nx_s;
            resp_pc_r     <= resp_pc_nx_s;
            q_count_r     <= q_count_nx_s;
            outstanding_r <= outstanding_nx_s;
            drop_cnt_r    <= drop_cnt_nx_s;
            head_r        <= head_nx_s;
            tail_r        <= tail_nx_s;
            started_r     <= 1'b1;
        end
    end

    // FIFO payload storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]    <= resp_pc_r;
            instr_mem_r[tail_r] <= bus.imem_resp_data;
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.out_valid      = out_valid_s;
    assign bus.out_instr      = instr_mem_r[head_r];
    assign bus.out_pc         = pc_mem_r[head_r];
    assign bus.busy           = !reset && ((outstanding_r != '0) || (drop_cnt_r != '0));

    fetch_prefetch_queue_chk #(.OUT_W(OUT_W)) u_chk (
        .clk             (clk),
        .reset           (reset),
        .imem_resp_valid (bus.imem_resp_valid),
        .outstanding     (outstanding_r)
    );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: queue-based reference model of requests in flight and buffered
// instructions, a variable-latency memory model, directed scenarios and a randomized soak.
module tb_fetch_prefetch_queue;
    localparam int          AW    = 32;
    localparam int          IW    = 32;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    fetch_prefetch_queue #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mreq_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: requests in flight (oldest m_stale of them are dropped) and the decode queue
    logic [31:0] m_fetch_pc;
    logic        m_started;
    int          m_stale;
    logic [31:0] m_inflight[$];
    logic [31:0] m_fifo[$];
    mreq_t       mem_q[$];
    logic [31:0] last_due;

    logic        ctl_rst, ctl_redir;
    logic [31:0] ctl_target;
    int          ready_pct, oready_pct, lat_min, lat_max;

    logic        ev_issue, ev_pop;
    logic [31:0] ev_issue_addr, ev_pop_pc;

    int          n_iss, n_pop, first_iss, first_ov, got, r;
    logic [31:0] iss_addr[2];
    logic [31:0] pops[4];
    logic [31:0] first_ov_pc, resume_addr, first_pop_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: drive inputs after the edge, compare against the model mid-cycle, advance the model
    task automatic step();
        logic        e_req, e_ov, e_busy, redir, resp;
        logic [31:0] tmp_pc, due;
        @(posedge clk);
        #1;
        cyc++;
        rst                 = ctl_rst;
        bus.redirect_valid  = ctl_redir;
        bus.redirect_target = ctl_target;
        bus.imem_req_ready  = ($urandom_range(99) < ready_pct);
        bus.out_ready       = ($urandom_range(99) < oready_pct);
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
        if (ctl_rst) begin
            mem_q.delete();
            last_due = 32'd0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= 32'(cyc)) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        ctl_rst   = 1'b0;
        ctl_redir = 1'b0;
        @(negedge clk);
        redir  = bus.redirect_valid;
        resp   = bus.imem_resp_valid;
        e_req  = !rst && m_started && !redir && (m_inflight.size() < MAXO)
                 && (m_fifo.size() + m_inflight.size() < DEPTH);
        e_ov   = !rst && (m_fifo.size() > 0);
        e_busy = !rst && (m_inflight.size() > 0);
        chk("req_valid", bus.imem_req_valid, e_req);
        if (e_req) chk("req_addr", bus.imem_req_addr, m_fetch_pc);
        chk("out_valid", bus.out_valid, e_ov);
        if (e_ov) begin
            chk("out_pc", bus.out_pc, m_fifo[0]);
            chk("out_instr", bus.out_instr, instr_of(m_fifo[0]));
        end
        chk("busy", bus.busy, e_busy);

        ev_issue      = bus.imem_req_valid && bus.imem_req_ready;
        ev_issue_addr = bus.imem_req_addr;
        ev_pop        = bus.out_valid && bus.out_ready && !redir;
        ev_pop_pc     = bus.out_pc;

        if (rst) begin
            m_fetch_pc = RPC;
            m_inflight.delete();
            m_fifo.delete();
            m_stale   = 0;
            m_started = 1'b0;
        end else begin
            m_started = 1'b1;
            if (redir) begin
                if (resp && m_inflight.size() > 0) void'(m_inflight.pop_front());
                m_stale    = m_inflight.size();
                m_fifo.delete();
                m_fetch_pc = bus.redirect_target & 32'hFFFF_FFFC;
            end else begin
                if (e_ov && bus.out_ready) void'(m_fifo.pop_front());
                if (resp && m_inflight.size() > 0) begin
                    tmp_pc = m_inflight.pop_front();
                    if (m_stale > 0) m_stale--;
                    else m_fifo.push_back(tmp_pc);
                end
                if (e_req && bus.imem_req_ready) begin
                    m_inflight.push_back(m_fetch_pc);
                    due = 32'(cyc + $urandom_range(lat_max, lat_min));
                    if (due < last_due) due = last_due;
                    last_due = due;
                    mem_q.push_back('{addr: m_fetch_pc, due: due});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
        bus.out_ready       = 1'b0;
        ctl_rst = 1'b0; ctl_redir = 1'b0; ctl_target = 32'd0;
        m_fetch_pc = RPC; m_started = 1'b0; m_stale = 0; last_due = 32'd0;

        // streaming from reset with a 1-cycle memory
        ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1;
        ctl_rst = 1'b1;
        step();
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_req_valid", bus.imem_req_valid, 32'd0);
        step();
        chk("post_rst_req_valid", bus.imem_req_valid, 32'd0);
        chk("post_rst_out_valid", bus.out_valid, 32'd0);
        iss_addr[0] = 32'hFFFF_FFFF; iss_addr[1] = 32'hFFFF_FFFF;
        n_iss = 0; first_iss = -1; first_ov = -1; first_ov_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ev_issue) begin
                if (n_iss < 2) iss_addr[n_iss] = ev_issue_addr;
                if (n_iss == 0) first_iss = cyc;
                n_iss++;
            end
            if (bus.out_valid && first_ov < 0) begin
                first_ov    = cyc;
                first_ov_pc = bus.out_pc;
            end
        end
        chk("a_addr0", iss_addr[0], 32'h0000_0100);
        chk("a_addr1", iss_addr[1], 32'h0000_0104);
        chk("a_latency", 32'(first_ov - first_iss), 32'd2);
        chk("a_first_pc", first_ov_pc, 32'h0000_0100);

        // decode stalled: queue fills, issue stops, then drains in order
        oready_pct = 0;
        ctl_rst = 1'b1;
        step();
        n_iss = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_issue) n_iss++;
        end
        chk("b_issued", 32'(n_iss), 32'd4);
        chk("b_req_valid", bus.imem_req_valid, 32'd0);
        chk("b_out_valid", bus.out_valid, 32'd1);
        oready_pct = 100; n_pop = 0; got = 0; resume_addr = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) pops[k] = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_pop && n_pop < 4) begin
                pops[n_pop] = ev_pop_pc;
                n_pop++;
            end
            if (ev_issue && got == 0) begin
                got = 1;
                resume_addr = ev_issue_addr;
            end
        end
        for (int k = 0; k < 4; k++) chk("b_drain", pops[k], 32'h0000_0100 + 32'(4 * k));
        chk("b_resume", resume_addr, 32'h0000_0110);

        // latency 3, redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        ctl_rst = 1'b1;
        step();
        got = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_q.size() == 2 && mem_q[0].due > 32'(cyc + 1)) begin
                got = 1;
                break;
            end
        end
        chk("c_setup", 32'(got), 32'd1);
        ctl_redir = 1'b1; ctl_target = 32'h0000_0203;
        step();
        got = 0; n_pop = 0; resume_addr = 32'hFFFF_FFFF; first_pop_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 2) chk("c_busy", bus.busy, 32'd1);
            if (ev_issue && got == 0) begin
                got = 1;
                resume_addr = ev_issue_addr;
            end
            if (ev_pop && n_pop == 0) begin
                n_pop = 1;
                first_pop_pc = ev_pop_pc;
            end
        end
        chk("c_addr", resume_addr, 32'h0000_0200);
        chk("c_first_pc", first_pop_pc, 32'h0000_0200);

        // redirect in the same cycle as a pop and a response
        lat_min = 1; lat_max = 2;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_fifo.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= 32'(cyc + 1)) begin
                got = 1;
                break;
            end
            step();
        end
        chk("d_setup", 32'(got), 32'd1);
        ctl_redir = 1'b1; ctl_target = 32'h0000_0400;
        step();
        step();
        chk("d_out_valid", bus.out_valid, 32'd0);
        n_pop = 0; first_pop_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_pop && n_pop == 0) begin
                n_pop = 1;
                first_pop_pc = ev_pop_pc;
            end
        end
        chk("d_first_pc", first_pop_pc, 32'h0000_0400);

        // PC wrap at the top of the address space; low target bits are ignored
        ctl_redir = 1'b1; ctl_target = 32'hFFFF_FFFE;
        step();
        n_iss = 0; iss_addr[0] = 32'h1234_5678; iss_addr[1] = 32'h1234_5678;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_issue && n_iss < 2) begin
                iss_addr[n_iss] = ev_issue_addr;
                n_iss++;
            end
        end
        chk("e_addr0", iss_addr[0], 32'hFFFF_FFFC);
        chk("e_addr1", iss_addr[1], 32'h0000_0000);

        // reset with a partly full queue and requests in flight
        oready_pct = 0; lat_min = 2; lat_max = 3;
        ctl_redir = 1'b1; ctl_target = 32'h0000_0800;
        step();
        for (int i = 0; i < 5; i++) step();
        ctl_rst = 1'b1;
        step();
        chk("f_rst_out_valid", bus.out_valid, 32'd0);
        chk("f_rst_busy", bus.busy, 32'd0);
        step();
        chk("f_post_out_valid", bus.out_valid, 32'd0);
        chk("f_post_busy", bus.busy, 32'd0);
        chk("f_post_req_valid", bus.imem_req_valid, 32'd0);
        oready_pct = 100; got = 0; resume_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ev_issue && got == 0) begin
                got = 1;
                resume_addr = ev_issue_addr;
            end
        end
        chk("f_resume", resume_addr, RPC);

        // randomized soak with redirects, resets, backpressure and variable latency
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                ready_pct  = $urandom_range(100, 20);
                oready_pct = $urandom_range(100, 0);
                lat_min    = 1;
                lat_max    = $urandom_range(4, 1);
            end
            r = $urandom_range(999);
            if (r < 3) begin
                ctl_rst = 1'b1;
            end else if (r < 30) begin
                ctl_redir  = 1'b1;
                ctl_target = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
